// File: rtl/data_memory_if.sv
// Load/store bus between the datapath and data_memory.
// The CPU (master) holds READ/WRITE until BUSYWAIT falls.
interface data_memory_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  READ;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] ADDRESS;
  logic [DATA_WIDTH-1:0] WRITEDATA;
  logic [DATA_WIDTH-1:0] READDATA;
  logic                  BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT
  );
endinterface

// File: rtl/data_memory.sv
// Data memory responder with fixed access latency.
// Stalls the CPU through BUSY, then acknowledges for exactly one cycle.
module data_memory #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LATENCY    = 5
) (
  input  logic         CLK,
  input  logic         RESET,
  data_memory_if.slave bus
);
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  generate
    if (LATENCY == 0) begin : g_latency_check
      $error("data_memory: LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_WIDTH-1:0]  counter;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] read_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  req;
  logic                  done;

  // Simultaneous READ and WRITE is not a request.
  assign req  = bus.READ ^ bus.WRITE;
  assign done = (state == BUSY) && (counter == '0);

  assign bus.READDATA = read_data;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = BUSY;
      BUSY:    if (done) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // BUSYWAIT is combinational in IDLE so the CPU stalls in the request cycle.
  always_comb begin
    bus.BUSYWAIT = 1'b0;
    case (state)
      IDLE:    bus.BUSYWAIT = req;
      BUSY:    bus.BUSYWAIT = 1'b1;
      default: bus.BUSYWAIT = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      counter   <= '0;
      op_write  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      read_data <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_WIDTH'(i)] <= '0;
      end
    end else begin
      if (state == IDLE && req) begin
        addr_q   <= bus.ADDRESS;
        data_q   <= bus.WRITEDATA;
        op_write <= bus.WRITE;
        counter  <= CNT_WIDTH'(LATENCY - 1);
      end
      // Only latched request fields are used once the access is in flight.
      if (state == BUSY) begin
        if (counter != '0) begin
          counter <= counter - CNT_WIDTH'(1);
        end else if (op_write) begin
          mem[addr_q] <= data_q;
        end else begin
          read_data <= mem[addr_q];
        end
      end
    end
  end
endmodule
